// File: rtl/crate_record_writer_if.sv
// Write-master control and FIFO write bundle between crate_record_writer (master)
// and the memory write master / its input FIFO (slave).
interface crate_record_writer_if;
    logic        control_fixed;
    logic        control_go;
    logic [31:0] control_write_base;
    logic [31:0] control_write_length;
    logic        control_done;
    logic [7:0]  user_buffer_input;
    logic        user_write_buffer;
    logic        user_buffer_full;

    modport master (
        output control_fixed,
        output control_go,
        output control_write_base,
        output control_write_length,
        input  control_done,
        output user_buffer_input,
        output user_write_buffer,
        input  user_buffer_full
    );

    modport slave (
        input  control_fixed,
        input  control_go,
        input  control_write_base,
        input  control_write_length,
        output control_done,
        input  user_buffer_input,
        input  user_write_buffer,
        output user_buffer_full
    );
endinterface

// File: rtl/crate_record_writer.sv
// Samples the crate lines, packs accepted samples into byte records and streams them to a memory ring.
// Optional macro CRATE_TIMESTAMP_EN prefixes each record with a 32-bit cycle timestamp (MSB first).
module crate_record_writer #(
    parameter int          DATA_W       = 8,
    parameter int          MOD_W        = 5,
    parameter int          PORT_W       = 2,
    parameter int          SAMPLE_DIV   = 30554432,
    parameter logic [31:0] BASE_ADDR    = 32'h10004000,
    parameter int          RING_RECORDS = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [MOD_W-1:0]      mod_sel,
    input  logic [PORT_W-1:0]     port_sel,
    input  logic                  mod_valid,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  trig_mode,
    crate_record_writer_if.master wm,
    output logic                  busy,
    output logic [15:0]           drop_count
);

`ifdef CRATE_TIMESTAMP_EN
    localparam int TS_BYTES = 4;
`else
    localparam int TS_BYTES = 0;
`endif
    localparam int REC_BYTES = 2 + TS_BYTES + DATA_W / 8;
    localparam int REC_W     = REC_BYTES * 8;
    localparam int SNAP_W    = MOD_W + PORT_W + DATA_W;
    localparam int CNT_W     = $clog2(SAMPLE_DIV);
    localparam int IDX_W     = (RING_RECORDS > 1) ? $clog2(RING_RECORDS) : 1;
    localparam int BI_W      = $clog2(REC_BYTES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_GO, S_BYTE, S_WAIT_DONE} state_t;

    state_t              state_q, state_d;
    logic [SNAP_W-1:0]   snap_s1_q, snap_s1_d, snap_s2_q, snap_s2_d;
    logic                valid_s1_q, valid_s1_d, valid_s2_q, valid_s2_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SNAP_W-1:0]   last_q, last_d;
    logic [REC_W-1:0]    rec_q, rec_d;
    logic [BI_W-1:0]     byte_idx_q, byte_idx_d;
    logic [31:0]         base_q, base_d;
    logic [31:0]         length_q, length_d;
    logic [15:0]         drop_q, drop_d;
`ifdef CRATE_TIMESTAMP_EN
    logic [31:0]         ts_q, ts_d;
`endif

    logic [MOD_W-1:0]    mod_s;
    logic [PORT_W-1:0]   port_s;
    logic [DATA_W-1:0]   data_s;
    logic                tick_s;
    logic                event_s;
    logic [REC_W-1:0]    rec_shift_s;
    logic [7:0]          cur_byte_s;

    assign mod_s       = snap_s2_q[SNAP_W-1 -: MOD_W];
    assign port_s      = snap_s2_q[DATA_W +: PORT_W];
    assign data_s      = snap_s2_q[DATA_W-1:0];
    assign tick_s      = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign event_s     = valid_s2_q && (trig_mode ? (snap_s2_q != last_q) : tick_s);
    // Byte 0 of the record sits in the top byte; shifting left walks through the record.
    assign rec_shift_s = rec_q << {byte_idx_q, 3'b000};
    assign cur_byte_s  = rec_shift_s[REC_W-1 -: 8];

    assign wm.control_fixed        = 1'b0;
    assign wm.control_go           = (state_q == S_GO);
    assign wm.control_write_base   = base_q;
    assign wm.control_write_length = length_q;
    assign wm.user_write_buffer    = (state_q == S_BYTE) && !wm.user_buffer_full;
    assign wm.user_buffer_input    = (state_q == S_BYTE) ? cur_byte_s : 8'h00;
    assign busy                    = (state_q != S_IDLE);
    assign drop_count              = drop_q;

    // Next-state: synchroniser, sample counter, drop accounting and the record FSM.
    always_comb begin
        state_d    = state_q;
        snap_s1_d  = {mod_sel, port_sel, data_in};
        snap_s2_d  = snap_s1_q;
        valid_s1_d = mod_valid;
        valid_s2_d = valid_s1_q;
        cnt_d      = tick_s ? '0 : cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        last_d     = last_q;
        rec_d      = rec_q;
        byte_idx_d = byte_idx_q;
        base_d     = base_q;
        length_d   = length_q;
        drop_d     = drop_q;
`ifdef CRATE_TIMESTAMP_EN
        ts_d       = ts_q + 32'd1;
`endif

        if (event_s && (state_q != S_IDLE) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end

        case (state_q)
            S_IDLE: begin
                if (event_s) begin
`ifdef CRATE_TIMESTAMP_EN
                    rec_d = {ts_q, 8'(mod_s), 8'(port_s), data_s};
`else
                    rec_d = {8'(mod_s), 8'(port_s), data_s};
`endif
                    last_d   = snap_s2_q;
                    base_d   = BASE_ADDR + 32'(idx_q) * 32'(REC_BYTES);
                    length_d = 32'(REC_BYTES);
                    state_d  = S_GO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GO: begin
                byte_idx_d = '0;
                state_d    = S_BYTE;
            end
            S_BYTE: begin
                if (!wm.user_buffer_full) begin
                    byte_idx_d = byte_idx_q + BI_W'(1);
                    if (byte_idx_q == BI_W'(REC_BYTES - 1)) begin
                        state_d = S_WAIT_DONE;
                    end else begin
                        state_d = S_BYTE;
                    end
                end else begin
                    state_d = S_BYTE;
                end
            end
            S_WAIT_DONE: begin
                if (wm.control_done) begin
                    idx_d   = (idx_q == IDX_W'(RING_RECORDS - 1)) ? '0 : idx_q + IDX_W'(1);
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transfer and rewinds the ring.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            snap_s1_q  <= '0;
            snap_s2_q  <= '0;
            valid_s1_q <= 1'b0;
            valid_s2_q <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            rec_q      <= '0;
            byte_idx_q <= '0;
            base_q     <= BASE_ADDR;
            length_q   <= 32'(REC_BYTES);
            drop_q     <= 16'h0000;
`ifdef CRATE_TIMESTAMP_EN
            ts_q       <= 32'h0000_0000;
`endif
        end else begin
            state_q    <= state_d;
            snap_s1_q  <= snap_s1_d;
            snap_s2_q  <= snap_s2_d;
            valid_s1_q <= valid_s1_d;
            valid_s2_q <= valid_s2_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            rec_q      <= rec_d;
            byte_idx_q <= byte_idx_d;
            base_q     <= base_d;
            length_q   <= length_d;
            drop_q     <= drop_d;
`ifdef CRATE_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

endmodule

// File: tb/tb_crate_record_writer.sv
// Directed bench for crate_record_writer: transaction-level model compared every cycle,
// plus hand-computed literal expectations for reset, capture, backpressure, wrap and drops.
module tb_crate_record_writer;
    localparam int          DATA_W       = 8;
    localparam int          MOD_W        = 5;
    localparam int          PORT_W       = 2;
    localparam int          SAMPLE_DIV   = 16;
    localparam int          RING_RECORDS = 4;
    localparam logic [31:0] BASE_ADDR    = 32'h10004000;
`ifdef CRATE_TIMESTAMP_EN
    localparam int TS_BYTES = 4;
`else
    localparam int TS_BYTES = 0;
`endif
    localparam int REC_BYTES = 2 + TS_BYTES + DATA_W / 8;
    localparam int SNAP_W    = MOD_W + PORT_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [MOD_W-1:0]  mod_sel = '0;
    logic [PORT_W-1:0] port_sel = '0;
    logic              mod_valid = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              trig_mode = 1'b0;
    logic              busy;
    logic [15:0]       drop_count;

    crate_record_writer_if wm_if ();

    crate_record_writer #(
        .DATA_W(DATA_W), .MOD_W(MOD_W), .PORT_W(PORT_W), .SAMPLE_DIV(SAMPLE_DIV),
        .BASE_ADDR(BASE_ADDR), .RING_RECORDS(RING_RECORDS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mod_sel(mod_sel), .port_sel(port_sel),
        .mod_valid(mod_valid), .data_in(data_in), .trig_mode(trig_mode),
        .wm(wm_if), .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int go_total = 0;
    int wr_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [SNAP_W:0]   m_p1, m_p2;
    logic [SNAP_W-1:0] m_snap, m_last;
    int                m_cnt, m_idx, m_drops;
    bit                m_active, m_go, m_ev, exp_wr;
    logic [7:0]        m_bytes[$];
    logic [31:0]       m_base;
`ifdef CRATE_TIMESTAMP_EN
    logic [31:0]       m_ts;
    int                cyc;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_p1 = '0; m_p2 = '0; m_last = '0;
            m_cnt = 0; m_idx = 0; m_drops = 0;
            m_active = 1'b0; m_go = 1'b0;
            m_bytes.delete();
            m_base = BASE_ADDR;
`ifdef CRATE_TIMESTAMP_EN
            m_ts = 32'h0;
            cyc = 0;
`endif
        end else begin
            m_snap = m_p2[SNAP_W-1:0];
            m_ev = m_p2[SNAP_W] && (trig_mode ? (m_snap != m_last) : (m_cnt == SAMPLE_DIV - 1));
            if (!m_active) begin
                if (m_ev) begin
                    m_bytes.delete();
`ifdef CRATE_TIMESTAMP_EN
                    for (int k = 3; k >= 0; k--) m_bytes.push_back(m_ts[k*8 +: 8]);
`endif
                    m_bytes.push_back(8'(m_snap[SNAP_W-1 -: MOD_W]));
                    m_bytes.push_back(8'(m_snap[DATA_W +: PORT_W]));
                    for (int k = DATA_W / 8 - 1; k >= 0; k--) m_bytes.push_back(m_snap[k*8 +: 8]);
                    m_last = m_snap;
                    m_base = BASE_ADDR + 32'(m_idx * REC_BYTES);
                    m_active = 1'b1;
                    m_go = 1'b1;
                end
            end else begin
                if (m_ev && m_drops < 65535) m_drops++;
                if (m_go) m_go = 1'b0;
                else if (m_bytes.size() > 0) begin
                    if (!wm_if.user_buffer_full) void'(m_bytes.pop_front());
                end else if (wm_if.control_done) begin
                    m_idx = (m_idx + 1) % RING_RECORDS;
                    m_active = 1'b0;
                end
            end
            m_p2 = m_p1;
            m_p1 = {mod_valid, mod_sel, port_sel, data_in};
            m_cnt = (m_cnt + 1) % SAMPLE_DIV;
`ifdef CRATE_TIMESTAMP_EN
            m_ts = m_ts + 32'd1;
            cyc = cyc + 1;
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            exp_wr = m_active && !m_go && (m_bytes.size() > 0) && !wm_if.user_buffer_full;
            chk("go", 32'(wm_if.control_go), 32'(m_go));
            chk("write", 32'(wm_if.user_write_buffer), 32'(exp_wr));
            if (exp_wr) chk("byte", 32'(wm_if.user_buffer_input), 32'(m_bytes[0]));
            chk("base", wm_if.control_write_base, m_base);
            chk("length", wm_if.control_write_length, 32'(REC_BYTES));
            chk("busy", 32'(busy), 32'(m_active));
            chk("drop", 32'(drop_count), 32'(m_drops));
            chk("fixed", 32'(wm_if.control_fixed), 32'd0);
            if (wm_if.control_go) go_total++;
            if (wm_if.user_write_buffer) wr_total++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_go(output int wr_at_go);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (wm_if.control_go === 1'b1) seen = 1'b1;
        end
        wr_at_go = wr_total;
        chk("go_seen", 32'(seen), 32'd1);
    endtask

    task automatic finish_record(input int wr_at_go);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            #1;
            if (wr_total >= wr_at_go + REC_BYTES) got = 1'b1;
        end
        chk("bytes_written", 32'(wr_total - wr_at_go), 32'(REC_BYTES));
        step();
        wm_if.control_done = 1'b1;
        step();
        wm_if.control_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, g0;
        logic [7:0]  t2_bytes [3];
        logic [31:0] ring_bases [5];
        t2_bytes = '{8'h01, 8'h02, 8'hA5};
`ifdef CRATE_TIMESTAMP_EN
        ring_bases = '{32'h10004000, 32'h10004007, 32'h1000400E, 32'h10004015, 32'h10004000};
`else
        ring_bases = '{32'h10004000, 32'h10004003, 32'h10004006, 32'h10004009, 32'h10004000};
`endif
        wm_if.control_done = 1'b0;
        wm_if.user_buffer_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Periodic capture with literal bytes
        mod_sel = 5'd1; port_sel = 2'd2; data_in = 8'hA5; mod_valid = 1'b1;
        wait_go(w);
        chk("t2_base", wm_if.control_write_base, 32'h10004000);
        chk("t2_len", wm_if.control_write_length, 32'(REC_BYTES));
        mod_valid = 1'b0;
        for (int k = 0; k < REC_BYTES; k++) begin
            @(negedge clk);
            if (k >= TS_BYTES) begin
                chk("t2_wr", 32'(wm_if.user_write_buffer), 32'd1);
                chk("t2_byte", 32'(wm_if.user_buffer_input), 32'(t2_bytes[k - TS_BYTES]));
            end
        end
        finish_record(w);
        @(negedge clk);
        chk("t2_idle", 32'(busy), 32'd0);

        // Backpressure after the module byte
        step();
        mod_valid = 1'b1;
        wait_go(w);
        mod_valid = 1'b0;
        for (int k = 0; k <= TS_BYTES; k++) @(negedge clk);
        chk("t3_byte0", 32'(wm_if.user_buffer_input), 32'h01);
        step();
        wm_if.user_buffer_full = 1'b1;
        @(negedge clk);
        chk("t3_hold0_wr", 32'(wm_if.user_write_buffer), 32'd0);
        chk("t3_hold0_byte", 32'(wm_if.user_buffer_input), 32'h02);
        step();
        @(negedge clk);
        chk("t3_hold1_wr", 32'(wm_if.user_write_buffer), 32'd0);
        chk("t3_hold1_byte", 32'(wm_if.user_buffer_input), 32'h02);
        step();
        wm_if.user_buffer_full = 1'b0;
        @(negedge clk);
        chk("t3_resume_wr", 32'(wm_if.user_write_buffer), 32'd1);
        chk("t3_resume_byte", 32'(wm_if.user_buffer_input), 32'h02);
        @(negedge clk);
        chk("t3_last_byte", 32'(wm_if.user_buffer_input), 32'hA5);
        finish_record(w);

        // Reset in the middle of a transfer
        step();
        mod_valid = 1'b1;
        wait_go(w);
        step();
        reset_n = 1'b0;
        #1;
        chk("rst_go", 32'(wm_if.control_go), 32'd0);
        chk("rst_wr", 32'(wm_if.user_write_buffer), 32'd0);
        chk("rst_byte", 32'(wm_if.user_buffer_input), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_base", wm_if.control_write_base, 32'h10004000);
        chk("rst_len", wm_if.control_write_length, 32'(REC_BYTES));
        chk("rst_fixed", 32'(wm_if.control_fixed), 32'd0);
        mod_valid = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;

        // Ring wrap over five periodic records
        mod_valid = 1'b1;
        for (int r = 0; r < 5; r++) begin
            wait_go(w);
            chk("t4_base", wm_if.control_write_base, ring_bases[r]);
            finish_record(w);
        end
        mod_valid = 1'b0;
        repeat (3) step();

        // Change-triggered capture and drop while busy
        trig_mode = 1'b1;
        mod_sel = 5'd3; port_sel = 2'd1; data_in = 8'h10;
        step();
        mod_valid = 1'b1;
        wait_go(w);
        finish_record(w);
        g0 = go_total;
        repeat (40) step();
        chk("t5_static_no_go", 32'(go_total - g0), 32'd0);
        data_in = 8'h11;
        wait_go(w);
        chk("t5_drop0", 32'(drop_count), 32'd0);
        step();
        data_in = 8'h12;
        step();
        data_in = 8'h11;
        finish_record(w);
        g0 = go_total;
        repeat (30) step();
        chk("t5_drop1", 32'(drop_count), 32'd1);
        chk("t5_no_second_go", 32'(go_total - g0), 32'd0);

`ifdef CRATE_TIMESTAMP_EN
        // Timestamped record accepted at cycle 0x123
        mod_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        trig_mode = 1'b1;
        mod_sel = 5'd2; port_sel = 2'd3; data_in = 8'h55;
        for (int i = 0; i < 1000 && cyc != 32'h121; i++) step();
        mod_valid = 1'b1;
        wait_go(w);
        chk("t6_len", wm_if.control_write_length, 32'd7);
        begin
            logic [7:0] t6_bytes [7];
            t6_bytes = '{8'h00, 8'h00, 8'h01, 8'h23, 8'h02, 8'h03, 8'h55};
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                chk("t6_byte", 32'(wm_if.user_buffer_input), 32'(t6_bytes[k]));
            end
        end
        finish_record(w);
        data_in = 8'h56;
        wait_go(w);
        chk("t6_stride", wm_if.control_write_base, 32'h10004007);
        finish_record(w);
`endif

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
